// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle multiply/divide sequencer beside the EX-stage ALU.
// Iterates a shift-add multiplier or a restoring divider one bit per cycle,
// holds the pipeline through stall while busy, and presents the result for
// a single done cycle.
// Optional feature: define MULDIV_SIGNED_EN for two's-complement operands
// (magnitudes are iterated, the sign is fixed up on the transition to DONE).
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request valid from ID/EX, sampled only in IDLE
//   op           00 MUL, 01 MULH, 10 DIV, 11 REM
//   A, B         multiplicand/dividend, multiplier/divisor
//   flush        aborts any operation in flight, blocks acceptance in IDLE
//   busy         high in MUL, DIV or DONE
//   stall        pipeline hold request (combinational from start in IDLE)
//   done         one-cycle completion pulse
//   result       selected result, valid with done, held until next accept
module ex_muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;       // MUL: {product hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor
  logic             sel_q, sel_d;       // op[0]: high half / remainder
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept_c;
  logic             last_c;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_nxt;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [W2-1:0]    div_nxt;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign accept_c = (state_q == S_IDLE) && start && !flush;
  assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));

  // Shift-add step: WIDTH+1-bit add keeps the carry, then shift right
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: trial-subtract against the shifted remainder (WIDTH+1 bits)
  assign div_ge   = (acc_q[W2-1:WIDTH-1] >= {1'b0, opnd_q});
  assign div_diff = acc_q[W2-2:WIDTH-1] - opnd_q;
  assign div_nxt  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[W2-2:0], 1'b0};

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d;     // product / quotient sign
  logic nega_q, nega_d;   // remainder sign follows the dividend

  assign a_abs    = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_abs    = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign prod_fix = neg_q ? (~mul_nxt + 1'b1) : mul_nxt;
  assign quo_fix  = neg_q ? (~div_nxt[WIDTH-1:0] + 1'b1) : div_nxt[WIDTH-1:0];
  assign rem_fix  = nega_q ? (~div_nxt[W2-1:WIDTH] + 1'b1) : div_nxt[W2-1:WIDTH];
`else
  assign a_abs    = A;
  assign b_abs    = B;
  assign prod_fix = mul_nxt;
  assign quo_fix  = div_nxt[WIDTH-1:0];
  assign rem_fix  = div_nxt[W2-1:WIDTH];
`endif

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sel_q    <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sel_q    <= sel_d;
      result_q <= result_d;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= neg_d;
      nega_q   <= nega_d;
`endif
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sel_d    = sel_q;
    result_d = result_q;
`ifdef MULDIV_SIGNED_EN
    neg_d    = neg_q;
    nega_d   = nega_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sel_d  = op[0];
          cnt_d  = '0;
          acc_d  = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          opnd_d = op[1] ? b_abs : a_abs;
`ifdef MULDIV_SIGNED_EN
          neg_d  = A[WIDTH-1] ^ B[WIDTH-1];
          nega_d = A[WIDTH-1];
`endif
          if (op[1] && (B == '0)) begin
            // Divide by zero: quotient all ones, remainder is the dividend
            state_d  = S_DONE;
            result_d = op[0] ? A : {WIDTH{1'b1}};
          end else begin
            state_d = op[1] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            state_d  = S_DONE;
            result_d = sel_q ? prod_fix[W2-1:WIDTH] : prod_fix[WIDTH-1:0];
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            state_d  = S_DONE;
            result_d = sel_q ? rem_fix : quo_fix;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: state decodes; done is suppressed while flush is asserted
  assign busy   = (state_q != S_IDLE);
  assign stall  = accept_c || (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_ex_muldiv_seq;

  localparam int unsigned WIDTH = 32;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       op    = 2'd0;
  logic [WIDTH-1:0] a_in  = '0;
  logic [WIDTH-1:0] b_in  = '0;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  int               total = 0;
  int               bad   = 0;
  logic [WIDTH-1:0] last_res = '0;

  always #5 clk = ~clk;

  ex_muldiv_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (a_in),
    .B      (b_in),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the full-width product / quotient
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(sa * sb);
`else
    p  = {32'd0, a} * {32'd0, b};
`endif
    case (o)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
`ifdef MULDIV_SIGNED_EN
        return 32'(sa / sb);
`else
        return a / b;
`endif
      end
      default: begin
        if (b == 32'd0) return a;
`ifdef MULDIV_SIGNED_EN
        return 32'(sa % sb);
`else
        return a % b;
`endif
      end
    endcase
  endfunction

  // Count cycles until done, bounded
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          lat;
    bit          dbz;
    exp = ref_model(o, a, b);
    dbz = o[1] && (b == 32'd0);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    #1 check("stall_on_req", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    check("stall_iter", 64'(stall), dbz ? 64'd0 : 64'd1);
    wait_done(1, lat);
    check("latency", 64'(lat), dbz ? 64'd1 : 64'd33);
    check("result", 64'(result), 64'(exp));
    check("stall_in_done", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("result_hold", 64'(result), 64'(exp));
    last_res = exp;
  endtask

  initial begin
    int lat;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors
    do_op(2'd0, 32'd7, 32'd6);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'd2, 32'd100, 32'd7);
    do_op(2'd3, 32'd100, 32'd7);
    do_op(2'd2, 32'hFFFF_FF9C, 32'd7);
    do_op(2'd3, 32'hFFFF_FF9C, 32'd7);
    do_op(2'd2, 32'h0000_1234, 32'd0);
    do_op(2'd3, 32'h0000_1234, 32'd0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush at iteration 10 of a DIV: no done, result untouched
    @(negedge clk); start = 1'b1; op = 2'd2; a_in = 32'd1000; b_in = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    #1 check("flush_div_done", 64'(done), 64'd0);
    @(posedge clk); #1; flush = 1'b0;
    check("flush_div_busy", 64'(busy), 64'd0);
    check("flush_div_done_next", 64'(done), 64'd0);
    check("flush_div_result", 64'(result), 64'(last_res));
    @(posedge clk); #1;
    check("flush_div_done_after", 64'(done), 64'd0);
    do_op(2'd2, 32'd1000, 32'd3);

    // Flush during the DONE cycle suppresses the pulse
    @(negedge clk); start = 1'b1; op = 2'd0; a_in = 32'd9; b_in = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    wait_done(1, lat);
    check("fdone_latency", 64'(lat), 64'd33);
    flush = 1'b1;
    #1 check("fdone_done", 64'(done), 64'd0);
    check("fdone_result", 64'(result), 64'(ref_model(2'd0, 32'd9, 32'd9)));
    @(posedge clk); #1; flush = 1'b0;
    check("fdone_busy", 64'(busy), 64'd0);
    check("fdone_done_next", 64'(done), 64'd0);

    // start together with flush in IDLE is ignored
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'd0; a_in = 32'd2; b_in = 32'd2;
    #1 check("sf_stall", 64'(stall), 64'd0);
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("sf_busy", 64'(busy), 64'd0);

    // start while busy is neither honoured nor queued
    @(negedge clk); start = 1'b1; op = 2'd0; a_in = 32'd7; b_in = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'd2; a_in = 32'd50; b_in = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    wait_done(5, lat);
    check("busy_start_latency", 64'(lat), 64'd33);
    check("busy_start_result", 64'(result), 64'd42);
    @(posedge clk); #1;
    check("busy_start_noqueue", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("busy_start_noqueue2", 64'(busy), 64'd0);

    // Asynchronous reset mid-MUL
    @(negedge clk); start = 1'b1; op = 2'd0; a_in = 32'hDEAD; b_in = 32'hBEEF;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    do_op(2'd0, 32'd3, 32'd5);

    // Randomized operations, back-to-back
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = 32'd0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) rb = 32'hFFFF_FFFF;
      else               rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      do_op(ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
